// File: rtl/mux_sel_serializer.sv
// Sequencer for an 8:1 mux tree: latches a word, then walks the select lines
// across every input, producing one serial beat per accepted output handshake.
module mux_sel_serializer #(
  parameter int LSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [7:0]       load_data,
  output logic             load_ready,
  output logic [7:0]       mux_i,
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             ser_last,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_cnt
);

  localparam logic [2:0] FIRST_IDX = (LSB_FIRST != 0) ? 3'd0 : 3'd7;
  localparam logic [2:0] LAST_IDX  = (LSB_FIRST != 0) ? 3'd7 : 3'd0;
  localparam logic [2:0] SEL_STEP  = (LSB_FIRST != 0) ? 3'd1 : 3'd7;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [7:0]       word_q, word_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic loadFire;
  logic beatFire;
  logic lastFire;

  assign beatFire = ser_valid & out_ready;
  assign lastFire = beatFire & ser_last;
  assign loadFire = load_valid & load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A load on the last beat keeps us in SHIFT so the next word follows with no bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (loadFire) state_d = SHIFT;
      SHIFT:   if (lastFire && !loadFire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ser_valid  = (state_q == SHIFT);
    ser_last   = ser_valid && (sel_q == LAST_IDX);
    load_ready = rst_n && ((state_q == IDLE) || (ser_valid && ser_last && out_ready));
  end

  always_comb begin
    word_d = word_q;
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    if (beatFire) begin
      sel_d = ser_last ? FIRST_IDX : (sel_q + SEL_STEP);
    end
    if (lastFire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (loadFire) begin
      word_d = load_data;
      sel_d  = FIRST_IDX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      sel_q  <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mux_i        = word_q;
  assign {s2, s1, s0} = sel_q;
  assign ser_bit      = word_q[sel_q];
  assign word_cnt     = cnt_q;

endmodule

// File: tb/tb_mux_sel_serializer.sv
// Bench for mux_sel_serializer: instance A is LSB-first with an 8-bit counter,
// instance B is MSB-first with a 2-bit counter so the wrap is reachable.
module tb_mux_sel_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       lvA = 1'b0, orA = 1'b0;
  logic [7:0] ldA = '0;
  logic       lrA, s0A, s1A, s2A, svA, sbA, slA;
  logic [7:0] muxA, cntA;

  logic       lvB = 1'b0, orB = 1'b0;
  logic [7:0] ldB = '0;
  logic       lrB, s0B, s1B, s2B, svB, sbB, slB;
  logic [7:0] muxB;
  logic [1:0] cntB;

  mux_sel_serializer #(.LSB_FIRST(1), .CNT_W(8)) dutA (
    .clk(clk), .rst_n(rst_n), .load_valid(lvA), .load_data(ldA), .load_ready(lrA),
    .mux_i(muxA), .s0(s0A), .s1(s1A), .s2(s2A), .ser_valid(svA), .ser_bit(sbA),
    .ser_last(slA), .out_ready(orA), .word_cnt(cntA)
  );

  mux_sel_serializer #(.LSB_FIRST(0), .CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .load_valid(lvB), .load_data(ldB), .load_ready(lrB),
    .mux_i(muxB), .s0(s0B), .s1(s1B), .s2(s2B), .ser_valid(svB), .ser_bit(sbB),
    .ser_last(slB), .out_ready(orB), .word_cnt(cntB)
  );

  int checks = 0;
  int passes = 0;

  // Word-level model: a busy flag, the beat index within the word, the held word and a count.
  bit         busyM[2];
  int         posM[2];
  logic [7:0] wordM[2];
  int         cntM[2];

  logic [15:0] capA, capB;
  int          beatA, beatB, busyA, lastAtA, lastAtB;
  logic [2:0]  firstSelB;

  function automatic logic mux4to1(input logic [3:0] d, input logic s1, input logic s0);
    return d[{s1, s0}];
  endfunction

  function automatic logic mux2to1(input logic a, input logic b, input logic s);
    return s ? b : a;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic modelStep(input int k, input logic lr, input logic [7:0] mx,
                           input logic [2:0] sel, input logic sv, input logic sb,
                           input logic sl, input int cnt, input logic lv,
                           input logic [7:0] ld, input logic ordy);
    string      t;
    int         cntMod;
    logic [2:0] expSel;
    logic       expReady;
    logic       y;
    t      = (k == 0) ? "A" : "B";
    cntMod = (k == 0) ? 256 : 4;
    if (!rst_n) begin
      checkOutput({t, ".rst.ser_valid"}, int'(sv), 0);
      checkOutput({t, ".rst.load_ready"}, int'(lr), 0);
      checkOutput({t, ".rst.ser_last"}, int'(sl), 0);
      checkOutput({t, ".rst.sel"}, int'(sel), 0);
      checkOutput({t, ".rst.mux_i"}, int'(mx), 0);
      checkOutput({t, ".rst.word_cnt"}, cnt, 0);
      busyM[k] = 1'b0;
      posM[k]  = 0;
      wordM[k] = '0;
      cntM[k]  = 0;
    end else begin
      expReady = !busyM[k] || (posM[k] == 7 && ordy);
      checkOutput({t, ".load_ready"}, int'(lr), int'(expReady));
      checkOutput({t, ".ser_valid"}, int'(sv), int'(busyM[k]));
      checkOutput({t, ".mux_i"}, int'(mx), int'(wordM[k]));
      checkOutput({t, ".word_cnt"}, cnt, cntM[k]);
      if (busyM[k]) begin
        expSel = (k == 0) ? 3'(posM[k]) : 3'(7 - posM[k]);
        y = mux2to1(mux4to1(mx[3:0], sel[1], sel[0]), mux4to1(mx[7:4], sel[1], sel[0]), sel[2]);
        checkOutput({t, ".sel"}, int'(sel), int'(expSel));
        checkOutput({t, ".ser_bit"}, int'(sb), int'(wordM[k][expSel]));
        checkOutput({t, ".ser_last"}, int'(sl), int'(posM[k] == 7));
        checkOutput({t, ".tree_y"}, int'(y), int'(sb));
      end else begin
        checkOutput({t, ".idle.ser_last"}, int'(sl), 0);
      end
      if (busyM[k] && ordy) begin
        if (posM[k] == 7) begin
          busyM[k] = 1'b0;
          cntM[k]  = (cntM[k] + 1) % cntMod;
        end else begin
          posM[k]++;
        end
      end
      if (lv && expReady) begin
        busyM[k] = 1'b1;
        posM[k]  = 0;
        wordM[k] = ld;
      end
    end
  endtask

  always @(negedge clk) begin
    modelStep(0, lrA, muxA, {s2A, s1A, s0A}, svA, sbA, slA, int'(cntA), lvA, ldA, orA);
    modelStep(1, lrB, muxB, {s2B, s1B, s0B}, svB, sbB, slB, int'(cntB), lvB, ldB, orB);
    if (rst_n) begin
      if (svA) busyA++;
      if (svA && orA) begin
        capA[beatA % 16] = sbA;
        if (slA) lastAtA = beatA;
        beatA++;
      end
      if (svB && orB) begin
        if (beatB == 0) firstSelB = {s2B, s1B, s0B};
        capB[beatB % 16] = sbB;
        if (slB) lastAtB = beatB;
        beatB++;
      end
    end
  end

  task automatic applyStimulus(input int k, input logic lv, input logic [7:0] d, input logic ordy);
    if (k == 0) begin
      lvA = lv; ldA = d; orA = ordy;
    end else begin
      lvB = lv; ldB = d; orB = ordy;
    end
  endtask

  task automatic nextCycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearCapture();
    capA = '0; capB = '0;
    beatA = 0; beatB = 0; busyA = 0;
    lastAtA = -1; lastAtB = -1;
    firstSelB = '0;
  endtask

  initial begin
    clearCapture();
    #1 rst_n = 1'b0;
    applyStimulus(0, 1'b1, 8'hAA, 1'b1);
    nextCycle(3);
    checkOutput("reset.load_ready", int'(lrA), 0);
    checkOutput("reset.ser_valid", int'(svA), 0);
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    rst_n = 1'b1;
    nextCycle(2);
    checkOutput("post_reset.load_ready", int'(lrA), 1);
    checkOutput("post_reset.ser_valid", int'(svA), 0);

    // Single word, downstream always ready.
    clearCapture();
    applyStimulus(0, 1'b1, 8'hB6, 1'b1);
    nextCycle(1);
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    nextCycle(10);
    checkOutput("t1.bits", int'(capA[7:0]), 'hB6);
    checkOutput("t1.beats", beatA, 8);
    checkOutput("t1.last_at", lastAtA, 7);
    checkOutput("t1.valid_cycles", busyA, 8);
    checkOutput("t1.word_cnt", int'(cntA), 1);

    // Same word with a stall on every other cycle.
    clearCapture();
    applyStimulus(0, 1'b1, 8'hB6, 1'b0);
    nextCycle(1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1'b0, 8'h00, logic'(i % 2));
      nextCycle(1);
    end
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    nextCycle(2);
    checkOutput("t2.bits", int'(capA[7:0]), 'hB6);
    checkOutput("t2.beats", beatA, 8);
    checkOutput("t2.valid_cycles", busyA, 16);
    checkOutput("t2.word_cnt", int'(cntA), 2);

    // Back-to-back words with load_valid held high.
    clearCapture();
    applyStimulus(0, 1'b1, 8'hB6, 1'b1);
    nextCycle(1);
    applyStimulus(0, 1'b1, 8'h5A, 1'b1);
    nextCycle(8);
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    nextCycle(10);
    checkOutput("t3.bits", int'(capA), 'h5AB6);
    checkOutput("t3.beats", beatA, 16);
    checkOutput("t3.valid_cycles", busyA, 16);
    checkOutput("t3.word_cnt", int'(cntA), 4);

    // MSB-first instance, then three more words to wrap its 2-bit counter.
    clearCapture();
    applyStimulus(1, 1'b1, 8'h80, 1'b1);
    nextCycle(1);
    applyStimulus(1, 1'b0, 8'h00, 1'b1);
    nextCycle(10);
    checkOutput("t4.bits", int'(capB[7:0]), 'h01);
    checkOutput("t4.first_sel", int'(firstSelB), 7);
    checkOutput("t4.last_at", lastAtB, 7);
    checkOutput("t4.word_cnt", int'(cntB), 1);
    applyStimulus(1, 1'b1, 8'hC3, 1'b1);
    nextCycle(17);
    applyStimulus(1, 1'b0, 8'h00, 1'b1);
    nextCycle(10);
    checkOutput("t4.wrap_cnt", int'(cntB), 0);

    // Reset in the middle of a word.
    clearCapture();
    applyStimulus(0, 1'b1, 8'hFF, 1'b1);
    nextCycle(1);
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    nextCycle(3);
    #2 rst_n = 1'b0;
    applyStimulus(0, 1'b1, 8'h55, 1'b1);
    #1;
    checkOutput("t5.beats_before", beatA, 3);
    checkOutput("t5.async.ser_valid", int'(svA), 0);
    checkOutput("t5.async.mux_i", int'(muxA), 0);
    checkOutput("t5.async.sel", int'({s2A, s1A, s0A}), 0);
    checkOutput("t5.async.load_ready", int'(lrA), 0);
    nextCycle(2);
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    rst_n = 1'b1;
    clearCapture();
    nextCycle(8);
    checkOutput("t5.valid_after", busyA, 0);
    checkOutput("t5.word_cnt", int'(cntA), 0);
    checkOutput("t5.load_ready", int'(lrA), 1);

    // Random words and backpressure on both instances.
    for (int c = 0; c < 300; c++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      applyStimulus(1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      nextCycle(1);
    end
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1, 1'b0, 8'h00, 1'b1);
    nextCycle(12);
    checkOutput("t6.drainA", int'(svA), 0);
    checkOutput("t6.drainB", int'(svB), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
